mem_arbiter: RTL

- Single-port RAM arbiter directly downstream of the icache and the dcache.
- Accepts icache read requests (iREN/iaddr) and dcache read/write requests (dREN/dWEN/daddr/dstore).
- Grants exactly one client at a time to the RAM and returns per-client iwait/dwait and load data.
- Round-robin on contention so neither fetch nor data traffic starves.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/rr_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, word type, and memory arbiter state encodings.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  localparam logic [1:0] ARB_IDLE   = 2'b00;
  localparam logic [1:0] ARB_IGRANT = 2'b01;
  localparam logic [1:0] ARB_DGRANT = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ARB_IDLE,
    IGRANT = ARB_IGRANT,
    DGRANT = ARB_DGRANT
  } ArbStateType;

endpackage

// File: rtl/rr_pick.sv
// Round-robin fairness rule for the memory arbiter: chooses which client gets the next grant.
module rr_pick
  import cpu_types_pkg::*;
(
  input  logic       ireq,
  input  logic       dreq,
  input  logic       last_d,
  output logic [1:0] grant
);

  // On contention the client that did not complete most recently wins.
  always_comb begin
    grant = ARB_IDLE;
    if (dreq && !ireq)
      grant = ARB_DGRANT;
    else if (ireq && !dreq)
      grant = ARB_IGRANT;
    else if (ireq && dreq)
      grant = last_d ? ARB_IGRANT : ARB_DGRANT;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache with round-robin grant and a
// one-cycle IDLE bubble after every completion.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr
);

  ArbStateType state;
  logic        last_d;
  logic        ireq;
  logic        dreq;
  logic [1:0]  pick;
  ramstate_t   rs;

  assign ireq  = iREN;
  assign dreq  = dREN | dWEN;
  assign rs    = ramstate_t'(ramstate);
  assign iload = ramload;
  assign dload = ramload;

  rr_pick u_pick (
    .ireq   (ireq),
    .dreq   (dreq),
    .last_d (last_d),
    .grant  (pick)
  );

  // A dropped request abandons the grant without touching last_d; ERROR keeps retrying.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
      memerr <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= ArbStateType'(pick);
        IGRANT: begin
          if (!ireq) begin
            state <= IDLE;
          end else if (rs == ACCESS) begin
            state  <= IDLE;
            last_d <= 1'b0;
          end else if (rs == ERROR) begin
            memerr <= 1'b1;
          end
        end
        DGRANT: begin
          if (!dreq) begin
            state <= IDLE;
          end else if (rs == ACCESS) begin
            state  <= IDLE;
            last_d <= 1'b1;
          end else if (rs == ERROR) begin
            memerr <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM drive follows the grant combinationally so a withdrawn request releases the RAM at once.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGRANT: begin
        if (ireq) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          iwait   = (rs != ACCESS);
        end
      end
      DGRANT: begin
        if (dreq) begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          dwait    = (rs != ACCESS);
        end
      end
      default: ;
    endcase
  end

endmodule
